frame_capture: RTL and testbench

Capture-side sink for the camera byte stream. It drives `camera_en` to request one frame, then accepts the `data_valid`/`data` byte stream as 3 bytes per pixel in R, G, B order. It assembles each 24-bit pixel, tags it with column/row coordinates and frame markers, computes an 8-bit luma value, and ends the request after exactly 3·N·M bytes. It sits between the camera source and downstream pixel-processing and frame-buffer logic.

---
 rtl/frame_capture.sv | 231 +++++++++++++++++++++++
 tb/tb_frame_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// frame_capture: camera byte-stream sink. It requests one frame, assembles R,G,B
// bytes into 24-bit pixels, tags each pixel with coordinates and frame markers,
// and computes an 8-bit luma value.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | camera disabled, waiting for start
// ARM     | camera enabled, waiting for the first byte (R of pixel 0,0)
// CAPTURE | taking R,G,B bytes and emitting one pixel per three bytes
// DONE    | one-cycle frame completion (frame_done, frame_count updated)
module frame_capture #(
  parameter int N  = 450,
  parameter int M  = 600,
  parameter int XW = $clog2(M),
  parameter int YW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          camera_en,
  input  logic          data_valid,
  input  logic [7:0]    data_in,
  output logic          pix_valid,
  output logic [23:0]   pix_rgb,
  output logic [7:0]    pix_gray,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic          busy,
  output logic          frame_done,
  output logic          aborted,
  output logic [15:0]   frame_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(M - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(N - 1);

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    r_q, r_d;
  logic [7:0]    g_q, g_d;
  logic          camera_en_q, camera_en_d;
  logic          pix_valid_q, pix_valid_d;
  logic [23:0]   pix_rgb_q, pix_rgb_d;
  logic [7:0]    pix_gray_q, pix_gray_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic          frame_done_q, frame_done_d;
  logic          aborted_q, aborted_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [9:0]    gray_sum;

  // Luma of the pixel completed by the current byte: R + 2G + B, at most 1020.
  always_comb begin
    gray_sum = {2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, data_in};
  end

  // Next-state and registered-output logic. Abort wins over start and bytes.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    x_d           = x_q;
    y_d           = y_q;
    r_d           = r_q;
    g_d           = g_q;
    camera_en_d   = camera_en_q;
    pix_valid_d   = 1'b0;
    pix_rgb_d     = pix_rgb_q;
    pix_gray_d    = pix_gray_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    sof_d         = 1'b0;
    eol_d         = 1'b0;
    eof_d         = 1'b0;
    frame_done_d  = 1'b0;
    aborted_d     = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        camera_en_d = 1'b0;
        if (start && !abort) begin
          state_d     = S_ARM;
          camera_en_d = 1'b1;
        end
      end

      S_ARM: begin
        if (abort) begin
          state_d     = S_IDLE;
          camera_en_d = 1'b0;
          aborted_d   = 1'b1;
          phase_d     = 2'd0;
          x_d         = '0;
          y_d         = '0;
        end else if (data_valid) begin
          r_d     = data_in;
          phase_d = 2'd1;
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (abort) begin
          state_d     = S_IDLE;
          camera_en_d = 1'b0;
          aborted_d   = 1'b1;
          phase_d     = 2'd0;
          x_d         = '0;
          y_d         = '0;
        end else if (data_valid) begin
          case (phase_q)
            2'd0: begin
              r_d     = data_in;
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = data_in;
              phase_d = 2'd2;
            end
            2'd2: begin
              phase_d     = 2'd0;
              pix_valid_d = 1'b1;
              pix_rgb_d   = {r_q, g_q, data_in};
              pix_gray_d  = 8'(gray_sum >> 2);
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              sof_d       = (x_q == '0) && (y_q == '0);
              eol_d       = (x_q == X_LAST);
              eof_d       = (x_q == X_LAST) && (y_q == Y_LAST);
              if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                  y_d           = '0;
                  state_d       = S_DONE;
                  camera_en_d   = 1'b0;
                  frame_done_d  = 1'b1;
                  frame_count_d = frame_count_q + 16'd1;
                end else begin
                  y_d = y_q + YW'(1);
                end
              end else begin
                x_d = x_q + XW'(1);
              end
            end
            default: phase_d = 2'd0;
          endcase
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      phase_q       <= 2'd0;
      x_q           <= '0;
      y_q           <= '0;
      r_q           <= 8'd0;
      g_q           <= 8'd0;
      camera_en_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_rgb_q     <= 24'd0;
      pix_gray_q    <= 8'd0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      eof_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      aborted_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      x_q           <= x_d;
      y_q           <= y_d;
      r_q           <= r_d;
      g_q           <= g_d;
      camera_en_q   <= camera_en_d;
      pix_valid_q   <= pix_valid_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_gray_q    <= pix_gray_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      eof_q         <= eof_d;
      frame_done_q  <= frame_done_d;
      aborted_q     <= aborted_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign camera_en   = camera_en_q;
  assign pix_valid   = pix_valid_q;
  assign pix_rgb     = pix_rgb_q;
  assign pix_gray    = pix_gray_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign eof         = eof_q;
  assign busy        = (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign frame_done  = frame_done_q;
  assign aborted     = aborted_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture on a 3x2 frame with a pixel scoreboard.
module tb_frame_capture;
  localparam int N  = 2;
  localparam int M  = 3;
  localparam int XW = 2;
  localparam int YW = 1;
  localparam int NB = 3 * N * M;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          camera_en;
  logic          data_valid;
  logic [7:0]    data_in;
  logic          pix_valid;
  logic [23:0]   pix_rgb;
  logic [7:0]    pix_gray;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          sof;
  logic          eol;
  logic          eof;
  logic          busy;
  logic          frame_done;
  logic          aborted;
  logic [15:0]   frame_count;

  frame_capture #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .camera_en(camera_en), .data_valid(data_valid), .data_in(data_in),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_gray(pix_gray),
    .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .frame_done(frame_done), .aborted(aborted),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  gray;
    int          x;
    int          y;
    logic        sof;
    logic        eol;
    logic        eof;
    int          cyc;
  } pix_t;

  pix_t       exp_q[$];
  pix_t       e_m;
  int         n_checks = 0;
  int         n_fail = 0;
  int         en_cycles = 0;
  logic [7:0] fb[NB];
  logic [7:0] r_m, g_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gray_f(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [9:0] s;
    s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return s[9:2];
  endfunction

  // Scoreboard side: pop and compare every pixel the DUT presents.
  always @(negedge clk) begin
    if (rst_n) begin
      if (camera_en) en_cycles++;
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          e_m = exp_q.pop_front();
          check("pix_rgb", pix_rgb, e_m.rgb);
          check("pix_gray", pix_gray, e_m.gray);
          check("pix_x", pix_x, e_m.x);
          check("pix_y", pix_y, e_m.y);
          check("sof", sof, e_m.sof);
          check("eol", eol, e_m.eol);
          check("eof", eof, e_m.eof);
          check("frame_done_with_eof", frame_done, e_m.eof);
          check("pix_cycle", pix_valid ? cyc : -1, e_m.cyc);
          if (e_m.eof) check("camera_en_at_eof", camera_en, 1'b0);
        end
      end else begin
        check("markers_idle", {sof, eol, eof, frame_done}, 4'b0000);
      end
    end
  end

  task automatic drive(input logic s, input logic ab, input logic dv, input logic [7:0] d);
    start = s;
    abort = ab;
    data_valid = dv;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int k, input logic ab, input logic st);
    pix_t e;
    logic [7:0] d;
    d = fb[k];
    case (k % 3)
      0: r_m = d;
      1: g_m = d;
      default: begin
        if (!ab) begin
          e.rgb  = {r_m, g_m, d};
          e.gray = gray_f(r_m, g_m, d);
          e.x    = (k / 3) % M;
          e.y    = (k / 3) / M;
          e.sof  = (k / 3 == 0);
          e.eol  = (e.x == M - 1);
          e.eof  = (k / 3 == N * M - 1);
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
        end
      end
    endcase
    drive(st, ab, 1'b1, d);
  endtask

  task automatic run_frame(input int stall_after, input int stall_len, input int start_at,
                           input int exp_count, input string tag);
    en_cycles = 0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < NB; k++) begin
      send_byte(k, 1'b0, k == start_at);
      if (k == stall_after) repeat (stall_len) drive(1'b0, 1'b0, 1'b0, 8'h55);
    end
    drive(1'b0, 1'b0, 1'b1, 8'hAA);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
    check({tag, "_pixels_left"}, exp_q.size(), 32'd0);
    check({tag, "_frame_count"}, frame_count, exp_count);
    check({tag, "_en_cycles"}, en_cycles, NB + ((stall_after < NB) ? stall_len : 0));
    check({tag, "_camera_en_off"}, camera_en, 1'b0);
    check({tag, "_busy_off"}, busy, 1'b0);
    check({tag, "_rgb_hold"}, pix_rgb, {fb[NB-3], fb[NB-2], fb[NB-1]});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    data_valid = 1'b0;
    data_in = 8'h00;
    for (int k = 0; k < NB; k++) fb[k] = 8'(k);

    #7;
    check("rst_camera_en", camera_en, 1'b0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_pix_rgb", pix_rgb, 24'h0);
    check("rst_pix_gray", pix_gray, 8'h0);
    check("rst_pix_xy", {pix_x, pix_y}, 3'b000);
    check("rst_markers", {sof, eol, eof, busy, frame_done, aborted}, 6'b0);
    check("rst_frame_count", frame_count, 16'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(NB, 0, NB, 1, "basic");
    run_frame(4, 4, NB, 2, "stall");

    fb[0] = 8'hFF; fb[1] = 8'hFF; fb[2] = 8'hFF;
    fb[3] = 8'h10; fb[4] = 8'h20; fb[5] = 8'h30;
    fb[6] = 8'h00; fb[7] = 8'hFF; fb[8] = 8'h00;
    for (int k = 9; k < NB; k++) fb[k] = 8'($urandom_range(0, 255));
    run_frame(NB, 0, NB, 3, "gray");
    for (int k = 0; k < NB; k++) fb[k] = 8'(k);

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) send_byte(k, 1'b0, 1'b0);
    send_byte(8, 1'b1, 1'b0);
    check("abort_pulse", aborted, 1'b1);
    check("abort_camera_en", camera_en, 1'b0);
    check("abort_no_pixel", pix_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("abort_pulse_end", aborted, 1'b0);
    check("abort_frame_count", frame_count, 16'd3);
    check("abort_pixels_left", exp_q.size(), 32'd0);
    run_frame(NB, 0, NB, 4, "post_abort");

    run_frame(NB, 0, 7, 5, "start_in_capture");

    drive(1'b1, 1'b1, 1'b0, 8'h00);
    check("idle_start_abort_en", camera_en, 1'b0);
    check("idle_start_abort_busy", busy, 1'b0);
    check("idle_abort_no_pulse", aborted, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("idle_stays_idle", busy, 1'b0);

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 7; k++) send_byte(k, 1'b0, 1'b0);
    data_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_camera_en", camera_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pix", {pix_valid, pix_rgb, pix_gray}, 33'h0);
    check("mid_rst_xy", {pix_x, pix_y}, 3'b000);
    check("mid_rst_flags", {sof, eol, eof, frame_done, aborted}, 5'b0);
    check("mid_rst_frame_count", frame_count, 16'd0);
    check("mid_rst_pixels_left", exp_q.size(), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(NB, 0, NB, 1, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
